// File: rtl/mdio_master.sv
// Clause 22 MDIO management master: serialises one read/write command at a time onto MDC/MDIO.
// MDC is a divided data output in the clk domain; MDIO is split into o/oe/i for the pad buffer.
//
// state   | meaning
// IDLE    | line released, cmd_ready high
// PRE     | PRE_LEN preamble ones
// ST_OP   | start (01) and opcode bits
// ADDR    | PHY address then register address
// TA      | turnaround; read samples the second bit for a PHY response
// DATA    | 16 data bits, driven on write, sampled on read
// END     | one released idle bit, rsp_valid on its last cycle
module mdio_master #(
  parameter int CLK_DIV = 10,
  parameter int PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_no_pre,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_ST_OP, S_ADDR, S_TA, S_DATA, S_END
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [6:0] PRE_LAST = 7'(PRE_LEN - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        mdc_q, mdc_d;
  logic [6:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic        write_q, write_d;
  logic        ta_err_q, ta_err_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        mdio_o_q, mdio_o_d;
  logic        mdio_oe_q, mdio_oe_d;

  logic tick, bit_end, rise;

  assign tick    = (div_q == DIV_LAST);
  assign bit_end = tick && mdc_q;
  assign rise    = tick && !mdc_q;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    mdc_d       = mdc_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    write_d     = write_q;
    ta_err_d    = ta_err_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mdio_o_d    = mdio_o_q;
    mdio_oe_d   = mdio_oe_q;

    if (state_q == S_IDLE) begin
      div_d = '0;
      mdc_d = 1'b0;
      if (cmd_valid) begin
        write_d   = cmd_write;
        ta_err_d  = 1'b0;
        // Read TA/DATA slots hold ones so the released line keeps its idle value
        tx_d      = cmd_write ? {4'b0101, cmd_phy_addr, cmd_reg_addr, 2'b10, cmd_wdata}
                              : {4'b0110, cmd_phy_addr, cmd_reg_addr, 2'b11, 16'hFFFF};
        mdio_oe_d = 1'b1;
        if (cmd_no_pre) begin
          state_d   = S_ST_OP;
          bit_cnt_d = 7'd3;
          mdio_o_d  = 1'b0;
        end else begin
          state_d   = S_PRE;
          bit_cnt_d = PRE_LAST;
          mdio_o_d  = 1'b1;
        end
      end
    end else begin
      if (tick) begin
        div_d = '0;
        mdc_d = ~mdc_q;
      end else begin
        div_d = div_q + 8'd1;
      end

      if (rise) begin
        if (state_q == S_TA && bit_cnt_q == 7'd0) ta_err_d = mdio_i;
        if (state_q == S_DATA) rx_d = {rx_q[14:0], mdio_i};
      end

      if (bit_end) begin
        if (state_q != S_PRE) tx_d = {tx_q[30:0], 1'b1};
        if (bit_cnt_q != 7'd0) begin
          bit_cnt_d = bit_cnt_q - 7'd1;
        end else begin
          case (state_q)
            S_PRE:   begin state_d = S_ST_OP; bit_cnt_d = 7'd3;  end
            S_ST_OP: begin state_d = S_ADDR;  bit_cnt_d = 7'd9;  end
            S_ADDR:  begin state_d = S_TA;    bit_cnt_d = 7'd1;  end
            S_TA:    begin state_d = S_DATA;  bit_cnt_d = 7'd15; end
            S_DATA: begin
              state_d   = S_END;
              bit_cnt_d = 7'd0;
              // Response registers settle at END entry so they are stable under rsp_valid
              if (!write_q) rsp_rdata_d = rx_q;
              rsp_err_d = !write_q && ta_err_q;
            end
            default: begin state_d = S_IDLE; bit_cnt_d = 7'd0; end
          endcase
        end

        case (state_d)
          S_PRE:          begin mdio_o_d = 1'b1;     mdio_oe_d = 1'b1;    end
          S_ST_OP, S_ADDR: begin mdio_o_d = tx_d[31]; mdio_oe_d = 1'b1;    end
          S_TA, S_DATA:   begin mdio_o_d = tx_d[31]; mdio_oe_d = write_q; end
          default:        begin mdio_o_d = 1'b1;     mdio_oe_d = 1'b0;    end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      mdc_q       <= 1'b0;
      bit_cnt_q   <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      write_q     <= 1'b0;
      ta_err_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mdio_o_q    <= 1'b1;
      mdio_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      mdc_q       <= mdc_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      write_q     <= write_d;
      ta_err_q    <= ta_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mdio_o_q    <= mdio_o_d;
      mdio_oe_q   <= mdio_oe_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_END) && bit_end;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mdc       = mdc_q;
  assign mdio_o    = mdio_o_q;
  assign mdio_oe   = mdio_oe_q;

endmodule

// File: tb/tb_mdio_master.sv
// Scoreboard bench for mdio_master: issued commands push expected responses and frames,
// a negedge monitor captures MDIO on mdc rising edges and checks each completion.
module tb_mdio_master;

  localparam int CLK_DIV = 10;
  localparam int PRE_LEN = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic        cmd_no_pre = 1'b0;
  logic [4:0]  cmd_phy_addr = '0;
  logic [4:0]  cmd_reg_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        mdio_i = 1'b1;
  logic        cmd_ready, rsp_valid, rsp_err, busy, mdc, mdio_o, mdio_oe;
  logic [15:0] rsp_rdata;

  mdio_master #(.CLK_DIV(CLK_DIV), .PRE_LEN(PRE_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_no_pre(cmd_no_pre), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .mdc(mdc), .mdio_o(mdio_o),
    .mdio_oe(mdio_oe), .mdio_i(mdio_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  rdata;
    logic         err;
    int           lat;
    int           nbits;
    logic [127:0] bits;
    logic [127:0] oe;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int n_acc = 0;
  int rsp_cyc = -100;

  // PHY model controls
  logic        phy_mode = 1'b0;
  int          phy_p = 0;
  logic [15:0] phy_data = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  function automatic exp_t mk(input logic w, input logic np, input logic [4:0] pa,
                              input logic [4:0] ra, input logic [15:0] wd,
                              input logic [15:0] er, input logic ee);
    exp_t e;
    int p;
    logic [13:0] hdr;
    logic [17:0] tail;
    p = np ? 0 : PRE_LEN;
    e.rdata = er;
    e.err   = ee;
    e.nbits = p + 33;
    e.lat   = 2 * CLK_DIV * (p + 33);
    e.bits  = '0;
    e.oe    = '0;
    for (int i = 0; i < p; i++) begin
      e.bits = {e.bits[126:0], 1'b1};
      e.oe   = {e.oe[126:0], 1'b1};
    end
    hdr = {2'b01, (w ? 2'b01 : 2'b10), pa, ra};
    for (int i = 13; i >= 0; i--) begin
      e.bits = {e.bits[126:0], hdr[i]};
      e.oe   = {e.oe[126:0], 1'b1};
    end
    tail = {2'b10, wd};
    for (int i = 17; i >= 0; i--) begin
      e.bits = {e.bits[126:0], (w ? tail[i] : 1'b0)};
      e.oe   = {e.oe[126:0], w};
    end
    e.bits = {e.bits[126:0], 1'b0};
    e.oe   = {e.oe[126:0], 1'b0};
    return e;
  endfunction

  function automatic logic phy_bit(input int j);
    if (!phy_mode) return 1'b1;
    if (j == phy_p + 15) return 1'b0;
    if (j >= phy_p + 16 && j <= phy_p + 31) return phy_data[15 - (j - phy_p - 16)];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) begin
      n_acc   <= n_acc + 1;
      acc_cyc <= cyc;
    end
  end

  int           seen_acc = 0;
  int           ncap = 0;
  logic [127:0] cap_bits = '0;
  logic [127:0] cap_oe = '0;
  logic         mdc_prev = 1'b0;

  always @(negedge clk) begin
    if (n_acc != seen_acc) begin
      seen_acc = n_acc;
      ncap     = 0;
      cap_bits = '0;
      cap_oe   = '0;
    end
    if (mdc && !mdc_prev) begin
      cap_bits = {cap_bits[126:0], mdio_o};
      cap_oe   = {cap_oe[126:0], mdio_oe};
      ncap++;
    end
    mdc_prev = mdc;
    if (rsp_valid) begin
      rsp_cyc = cyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 want no response");
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", 128'(rsp_rdata), 128'(mon_e.rdata));
        chk("rsp_err", 128'(rsp_err), 128'(mon_e.err));
        chk("latency", 128'(cyc - acc_cyc), 128'(mon_e.lat));
        chk("frame_len", 128'(ncap), 128'(mon_e.nbits));
        chk("frame_bits", cap_bits & mon_e.oe, mon_e.bits & mon_e.oe);
        chk("frame_oe", cap_oe, mon_e.oe);
      end
    end
    mdio_i = phy_bit(ncap);
  end

  task automatic issue(input logic w, input logic np, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd, input logic [15:0] er, input logic ee,
                       input logic hold);
    @(negedge clk);
    cmd_write    = w;
    cmd_no_pre   = np;
    cmd_phy_addr = pa;
    cmd_reg_addr = ra;
    cmd_wdata    = wd;
    cmd_valid    = 1'b1;
    exp_q.push_back(mk(w, np, pa, ra, wd, er, ee));
    for (int i = 0; i < 4000; i++) begin
      if (cmd_ready) break;
      @(negedge clk);
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got cmd_ready=0 want 1");
    end
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 4000; i++) begin
      if (exp_q.size() == 0 && cmd_ready) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0 || !cmd_ready) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got pending=%0d want 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  int na;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_rdata", 128'(rsp_rdata), 128'(0));
    chk("rst_err", 128'(rsp_err), 128'(0));
    chk("rst_mdc", 128'(mdc), 128'(0));
    chk("rst_mdio_o", 128'(mdio_o), 128'(1));
    chk("rst_mdio_oe", 128'(mdio_oe), 128'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // write with preamble, PHY 1 reg 0 data 0x1140
    issue(1'b1, 1'b0, 5'h01, 5'h00, 16'h1140, 16'h0000, 1'b0, 1'b0);
    chk("busy_in_frame", 128'(busy), 128'(1));
    wait_done();
    chk("idle_mdc", 128'(mdc), 128'(0));
    chk("idle_mdio_o", 128'(mdio_o), 128'(1));
    chk("idle_mdio_oe", 128'(mdio_oe), 128'(0));

    // read with a responding PHY
    phy_mode = 1'b1; phy_p = PRE_LEN; phy_data = 16'h0141;
    issue(1'b0, 1'b0, 5'h03, 5'h02, 16'h0000, 16'h0141, 1'b0, 1'b0);
    wait_done();

    // read with no PHY: line pulled high
    phy_mode = 1'b0;
    issue(1'b0, 1'b0, 5'h05, 5'h01, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
    wait_done();

    // write without preamble clears err, keeps rdata
    issue(1'b1, 1'b1, 5'h02, 5'h04, 16'hA5C3, 16'hFFFF, 1'b0, 1'b0);
    wait_done();

    // back-to-back with cmd_valid held high
    phy_mode = 1'b1; phy_p = 0; phy_data = 16'hBEEF;
    issue(1'b1, 1'b1, 5'h07, 5'h09, 16'h0F0F, 16'hFFFF, 1'b0, 1'b1);
    issue(1'b0, 1'b1, 5'h03, 5'h02, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
    chk("b2b_accept_cycle", 128'(acc_cyc), 128'(rsp_cyc + 1));
    na = n_acc;
    repeat (4) begin
      repeat (40) @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    wait_done();
    chk("busy_pulses_ignored", 128'(n_acc), 128'(na));

    // reset during ADDR
    phy_mode = 1'b0;
    issue(1'b1, 1'b1, 5'h0A, 5'h15, 16'h1234, 16'h0000, 1'b0, 1'b0);
    repeat (120) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_mdc", 128'(mdc), 128'(0));
    chk("abort_mdio_oe", 128'(mdio_oe), 128'(0));
    chk("abort_mdio_o", 128'(mdio_o), 128'(1));
    chk("abort_cmd_ready", 128'(cmd_ready), 128'(1));
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (800) @(negedge clk);
    chk("abort_rdata_reset", 128'(rsp_rdata), 128'(0));

    // normal write after reset
    issue(1'b1, 1'b0, 5'h01, 5'h1F, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdio_master.md
# mdio_master

Parametrised IEEE 802.3 Clause 22 MDIO management master for the Ethernet MMIO peripheral. It accepts one read or write command at a time over a valid/ready handshake and serialises it onto MDC/MDIO, running entirely in the `clk` domain. MDC is generated as a data output, not used as a clock. Compared with the previous driver, it adds a run-time PHY address, configurable clock division, configurable preamble length with per-command suppression, a split tristate interface, and turnaround error detection. The MMIO register block sits above it, and the top-level I/O buffer sits below it.

## Interface
- `CLK_DIV`, default 10: `clk` cycles per MDC half-period. Legal range is 2..255.
- `PRE_LEN`, default 32: preamble length in bits. Legal range is 1..64.
- `clk` input 1: system clock. The whole block runs in this single clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: block is idle and can accept a command.
- `cmd_write` input 1: 1 selects write, 0 selects read.
- `cmd_no_pre` input 1: 1 suppresses the preamble for this command.
- `cmd_phy_addr` input 5: PHY address.
- `cmd_reg_addr` input 5: register address.
- `cmd_wdata` input 16: write data.
- `rsp_valid` output 1: one-cycle completion pulse.
- `rsp_rdata` output 16: read data, held until the next read completes.
- `rsp_err` output 1: read turnaround error, held until the next completion.
- `busy` output 1: a frame is in progress.
- `mdc` output 1: management clock to the PHY.
- `mdio_o` output 1: MDIO output value.
- `mdio_oe` output 1: MDIO output enable.
- `mdio_i` input 1: MDIO pin input.

## Operation
- **State machine:** IDLE → PRE → ST_OP → ADDR → TA → DATA → END → IDLE.
  - PRE is skipped when `cmd_no_pre`=1; the machine goes straight from IDLE to ST_OP.
- **Command acceptance:** a command is accepted when `cmd_valid && cmd_ready`.
  - All `cmd_*` fields are latched at that edge.
  - `cmd_ready` = (state==IDLE).
  - `busy` = !`cmd_ready`.
  - `cmd_valid` is ignored while busy.
- **Frame bit sequence**, MSB first within every field:
  - PRE: `PRE_LEN` ones.
  - ST: 01.
  - OP: 01 for a write, 10 for a read.
  - PHYAD: 5 bits.
  - REGAD: 5 bits.
  - TA: 2 bits.
  - DATA: 16 bits.
  - END: one idle bit with `mdio_oe`=0.
- **Write:**
  - TA is driven as 10.
  - DATA is driven from `cmd_wdata`.
  - `mdio_oe`=1 from the first PRE (or ST) bit through D0.
- **Read:**
  - `mdio_oe`=1 through REGAD bit 0, then 0 from TA bit 1 onward.
  - `mdio_i` is sampled at the second TA bit. If the sample is 1 (no PHY present), set `rsp_err`=1.
  - D15..D0 are sampled into a shift register and copied to `rsp_rdata` at END, even when `rsp_err`=1.
- **Completion:**
  - `rsp_valid` pulses for one cycle as the machine leaves END.
  - A write completion clears `rsp_err` and leaves `rsp_rdata` unchanged.
  - A read completion updates both `rsp_rdata` and `rsp_err`.
  - There is no response backpressure.
- **Idle line state:** `mdc`=0, `mdio_oe`=0, `mdio_o`=1.

## Timing
- **Bit period:** 2·`CLK_DIV` cycles.
  - Low phase: `CLK_DIV` cycles.
  - High phase: `CLK_DIV` cycles.
- **Output updates:** `mdio_o` and `mdio_oe` change only at the first cycle of a bit's low phase.
  - This is `mdc` falling, or the start of the first bit.
- **Input sampling:** `mdio_i` is sampled at the clock edge where `mdc` goes 0→1.
- **First bit:** its low phase begins on the cycle after the accepting edge.
- **Latency:** `rsp_valid` is high exactly 2·`CLK_DIV`·(P+33) cycles after the accepting edge, where P = `PRE_LEN`, or 0 when `cmd_no_pre`=1.
- **Return to idle:** `cmd_ready` returns to 1 on the cycle after `rsp_valid`.
  - Back-to-back commands can therefore be accepted no earlier than that cycle.
- **Reset values:**
  - `cmd_ready`=1, `busy`=0
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0
  - `mdc`=0, `mdio_o`=1, `mdio_oe`=0
- **Counters:**
  - Divider counter: 8 bits; wraps to 0 at `CLK_DIV`-1.
  - Bit counter: 7 bits; reloads at each state change.
- **Reset mid-frame:** all state and outputs go to their reset values immediately (asynchronously). No `rsp_valid` is issued for the aborted frame, and the line is released.

## Test plan
- **Write with preamble.**
  - Stimulus: `CLK_DIV`=10, `PRE_LEN`=32; write PHY 0x01, reg 0x00, data 0x1140.
  - Required response: capture MDIO on `mdc` rising edges and get 32 ones, then 0101 00001 00000 10 0001000101000000.
  - Required response: `rsp_valid` is high at cycle 1300 after accept, with `rsp_err`=0.
- **Read.**
  - Stimulus: read PHY 0x03, reg 0x02; the PHY model drives TA=Z0 and data 0x0141 after `mdc` rises.
  - Required response: `rsp_rdata`=0x0141, `rsp_err`=0.
  - Required response: `mdio_oe`=0 from TA bit 1 through END.
- **No PHY.**
  - Stimulus: a read with `mdio_i` pulled to 1.
  - Required response: `rsp_err`=1, `rsp_rdata`=0xFFFF.
  - Required response: a following write clears `rsp_err` to 0.
- **Preamble suppression.**
  - Stimulus: a write with `cmd_no_pre`=1.
  - Required response: the first bit captured is ST 0, and `rsp_valid` arrives at cycle 660.
- **Back-to-back commands.**
  - Stimulus: `cmd_valid` held high with two commands.
  - Required response: the second command is accepted on the cycle after `rsp_valid`.
  - Required response: `cmd_valid` pulses during busy are ignored, with no extra frames.
- **Reset mid-frame.**
  - Stimulus: assert `rst_n`=0 during the ADDR state.
  - Required response: `mdc`=0, `mdio_oe`=0, `cmd_ready`=1 immediately, and no `rsp_valid`.
  - Required response: a new write after reset completes normally.
